// File: rtl/chacha_pkg.sv
// chacha_pkg: shared constants and state encoding for the chacha keystream XOR stage.
package chacha_pkg;
  localparam int KS_BYTES_DEF = 64;
  localparam int IDX_W = $clog2(KS_BYTES_DEF);
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_STREAM = 2'd2
  } state_t;
endpackage

// File: rtl/chacha_ks_buf.sv
// chacha_ks_buf: keystream block buffer, one synchronous write port and one combinational read port.
module chacha_ks_buf
  import chacha_pkg::*;
#(
  parameter int DEPTH = KS_BYTES_DEF,
  parameter int IW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [IW-1:0] i_wr_idx,
  input  logic [7:0]    i_wr_data,
  input  logic [IW-1:0] i_rd_idx,
  output logic [7:0]    o_rd_data
);
  logic [7:0] r_mem [DEPTH];
  always_ff @(posedge clk)
    if (i_we) r_mem[i_wr_idx] <= i_wr_data;
  assign o_rd_data = r_mem[i_rd_idx];
endmodule

// File: rtl/chacha_xor_stream.sv
// chacha_xor_stream: buffers one keystream block from the core's burst port and XORs it into a byte stream.
// Optional early block discard via the flush port when CHACHA_XOR_FLUSH_EN is defined.
module chacha_xor_stream
  import chacha_pkg::*;
#(
  parameter int KS_BYTES = KS_BYTES_DEF,
  parameter int CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ks_blk_ready,
  output logic             ks_rd_blk,
  input  logic [7:0]       ks_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_data,
  output logic [CNT_W-1:0] blk_done,
`ifdef CHACHA_XOR_FLUSH_EN
  input  logic             flush,
`endif
  output logic             busy
);
  localparam int IW = $clog2(KS_BYTES);
  localparam logic [IW-1:0] LAST = IW'(KS_BYTES - 1);

  state_t           r_state, w_next;
  logic [IW-1:0]    r_ld_idx, r_rd_idx;
  logic             r_out_valid;
  logic [7:0]       r_out_data;
  logic [CNT_W-1:0] r_blk_done;
  logic             w_flush, w_fire, w_end, w_count;
  logic [7:0]       w_ks;

`ifdef CHACHA_XOR_FLUSH_EN
  assign w_flush = flush && r_state == ST_STREAM;
`else
  assign w_flush = 1'b0;
`endif
  assign w_fire  = in_valid && in_ready;
  assign w_end   = w_fire && r_rd_idx == LAST;
  // A flushed block counts as consumed only if at least one byte of it was used
  assign w_count = w_end || (w_flush && r_rd_idx != '0);

  chacha_ks_buf #(.DEPTH(KS_BYTES), .IW(IW)) u_buf (
    .clk      (clk),
    .i_we     (r_state == ST_LOAD),
    .i_wr_idx (r_ld_idx),
    .i_wr_data(ks_data),
    .i_rd_idx (r_rd_idx),
    .o_rd_data(w_ks)
  );

  always_ff @(posedge clk)
    if (!rst_n) r_state <= ST_IDLE;
    else r_state <= w_next;

  always_comb begin
    w_next = r_state == ST_IDLE   ? (ks_blk_ready ? ST_LOAD : ST_IDLE) :
             r_state == ST_LOAD   ? (r_ld_idx == LAST ? ST_STREAM : ST_LOAD) :
             r_state == ST_STREAM ? ((w_end || w_flush) ? ST_IDLE : ST_STREAM) :
                                    ST_IDLE;
  end

  always_comb begin
    ks_rd_blk = r_state == ST_LOAD && r_ld_idx == '0;
    in_ready  = r_state == ST_STREAM && !w_flush && (!r_out_valid || out_ready);
    busy      = r_state != ST_IDLE;
  end

  // Load index wraps to zero on the last byte since KS_BYTES is a power of two
  always_ff @(posedge clk)
    if (!rst_n) begin
      r_ld_idx    <= '0;
      r_rd_idx    <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= 8'h00;
      r_blk_done  <= '0;
    end else begin
      if (r_state == ST_LOAD) r_ld_idx <= r_ld_idx + 1'b1;
      if (w_flush) r_rd_idx <= '0;
      else if (w_fire) r_rd_idx <= r_rd_idx + 1'b1;
      if (w_count) r_blk_done <= r_blk_done + 1'b1;
      if (w_fire) begin
        r_out_data  <= in_data ^ w_ks;
        r_out_valid <= 1'b1;
      end else if (out_ready) r_out_valid <= 1'b0;
    end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign blk_done  = r_blk_done;
endmodule

// File: doc/chacha_xor_stream.md
Name: chacha_xor_stream

Overview:
- Downstream consumer of the chacha keystream core.
- Pulls each 64-byte block over the core's burst read interface (blk_ready / rd_blk / data_out) into a local keystream buffer.
- XORs the buffer with a byte stream under valid/ready handshakes, producing ciphertext or plaintext.
- Sits between the chacha core and the byte-stream fabric. It hides the core's non-stallable 64-cycle read burst behind flow-controlled ports.

Parameters:
- KS_BYTES, 64: keystream bytes per block; must equal the core's block size; power of two.
- CNT_W, 32: width of the completed-block counter.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, synchronous, active-low.
- ks_blk_ready  in  1  core block-available flag.
- ks_rd_blk  out  1  read-start pulse to the core.
- ks_data  in  8  core block data bus.
- in_valid  in  1  input byte valid.
- in_ready  out  1  input byte accepted when high together with in_valid.
- in_data  in  8  plaintext/ciphertext byte.
- out_valid  out  1  output byte valid.
- out_ready  in  1  downstream accepts the output byte.
- out_data  out  8  in_data XOR keystream byte.
- blk_done  out  CNT_W  count of fully consumed keystream blocks; wraps.
- busy  out  1  high in LOAD or STREAM.

Behaviour:
- Reset values (synchronous, overrides everything, including mid-LOAD or mid-STREAM):
  - state=IDLE, ld_idx=0, rd_idx=0.
  - out_valid=0, out_data=0, blk_done=0.
  - ks_rd_blk=0, in_ready=0.
  - Buffer contents are don't-care.
- IDLE: if ks_blk_ready=1, go to LOAD next cycle. Otherwise stay.
- LOAD:
  - ks_rd_blk = (state==LOAD && ld_idx==0), so exactly one pulse per block.
  - Every LOAD cycle, buf[ld_idx] <= ks_data and ld_idx increments.
  - The first capture happens in the same cycle as ks_rd_blk, because the core presents byte 0 combinationally.
  - At ld_idx==KS_BYTES-1: go to STREAM, ld_idx<=0.
  - LOAD never stalls. Input and output handshakes are ignored for admission, but out_valid/out_data still drain normally.
- STREAM:
  - in_ready = (state==STREAM) && (!out_valid || out_ready).
  - Fire = in_valid && in_ready. On fire: out_data <= in_data ^ buf[rd_idx], out_valid<=1, rd_idx increments.
  - If out_ready=1 and there is no fire, out_valid<=0.
  - While out_valid && !out_ready, out_data/out_valid hold stable.
  - Fire at rd_idx==KS_BYTES-1: rd_idx<=0, blk_done increments (wraps at 2^CNT_W), state<=IDLE.
  - The last output byte may still be pending in IDLE or LOAD; it drains normally.
- Latency: one cycle from input fire to out_valid.
- Throughput: one byte/cycle within a block. Block refill costs at least 65 cycles (1 IDLE + 64 LOAD) while the core has a block ready.
- in_ready is 0 in IDLE and LOAD.
- Keystream byte k of each block is the k-th byte delivered by the core in the burst.
- Keystream bytes are never reused: each buffered byte is consumed exactly once.

Optional Feature:
- Macro: CHACHA_XOR_FLUSH_EN.
- When defined, adds input port flush (1 bit).
  - flush=1 in STREAM: discard remaining keystream, rd_idx<=0, state<=IDLE. blk_done increments if rd_idx!=0.
  - A simultaneous fire in that cycle is blocked: in_ready is forced 0 while flush=1.
  - A pending out_valid byte is preserved.
  - flush is ignored in IDLE and LOAD.
- When undefined: port absent; a block ends only after KS_BYTES fires.

Decomposition:
- Package chacha_pkg:
  - KS_BYTES default constant.
  - state encoding constants ST_IDLE, ST_LOAD, ST_STREAM.
  - index width localparam = log2(KS_BYTES).
- Sub-module chacha_ks_buf: KS_BYTES x 8 register file; one synchronous write port (LOAD), one combinational read port (rd_idx).

Test Plan:
- Core stub asserts ks_blk_ready and drives byte k = k^8'hA5 during the burst.
  - Expect exactly one ks_rd_blk pulse, coincident with ks_data=8'hA5; busy=1 for 64 LOAD cycles.
  - Then stream 64 bytes in_data=8'h00 with out_ready=1 -> out_data sequence A5,A4,A7,...,9A. blk_done=1. in_ready=0 after byte 63.
- Backpressure: out_ready=0 for 5 cycles after the first fire -> out_data held at input^A5, in_ready=0. Release -> no loss or duplication across all 64 bytes.
- Two blocks back-to-back, input byte i = i[7:0] for i=0..127 -> block 2 uses fresh keystream starting at index 0 (out byte 64 = 8'h40^8'hA5). blk_done=2.
- Reset asserted at ld_idx=30 -> next cycle state IDLE, out_valid=0, ks_rd_blk=0. A fresh ks_blk_ready restarts the load at byte 0.
- Sparse in_valid (every third cycle) -> out_valid is 1 cycle after each fire; outputs match reference XOR.
- CHACHA_XOR_FLUSH_EN: flush after 10 bytes -> IDLE, blk_done=1. The next block's first output uses keystream byte 0.
